// File: rtl/data_mem_responder.sv
// Responder for the core's data-memory port: word-organised RAM with byte/half/word
// access, a programmable number of wait states and a one-cycle registered completion pulse.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Handshake: a request (mem_read|mem_write) is accepted on any rising edge while
  // state is IDLE; its inputs are latched there and ignored afterwards. Completion is
  // signalled by ready=1 for exactly one cycle, WAIT_CYCLES+1 cycles after acceptance,
  // together with rdata and misalign_err. The requester must drop its request on the
  // edge that samples ready, otherwise it is accepted again as a fresh request.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;

  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      funct3_q;
  logic            write_q;

  logic            req;
  logic            use_in;
  logic [AW+1:0]   eff_addr;
  logic [31:0]     eff_wdata;
  logic [2:0]      eff_funct3;
  logic            eff_write;
  logic            eff_err;
  logic            commit;
  logic [3:0]      be;
  logic [3:0][7:0] wlanes;

  logic [3:0][7:0] ram [DEPTH];
  logic [31:0]     rd_word;

  logic [31:0]     rdata_d;
  logic            ready_d;
  logic            err_d;

  logic            unused_addr;
  assign unused_addr = &{1'b0, addr[31:AW+2]};

  function automatic logic access_err(input logic [2:0] f3, input logic [1:0] lane,
                                      input logic wr);
    logic e;
    case (f3)
      3'b000:         e = 1'b0;
      3'b001:         e = lane[0];
      3'b010:         e = (lane != 2'b00);
      3'b100, 3'b101: e = wr;
      default:        e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  v = {{24{b[7]}}, b};
      3'b001:  v = {{16{h[15]}}, h};
      3'b010:  v = word;
      3'b100:  v = {24'd0, b};
      3'b101:  v = {16'd0, h};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  assign req = mem_read | mem_write;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_next   = CNT_LOAD;
          state_next = (WAIT_CYCLES > 0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        cnt_next = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture; write wins when both strobes are high
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_q   <= addr[AW+1:0];
      wdata_q  <= wdata;
      funct3_q <= funct3;
      write_q  <= mem_write;
    end
  end

  // With no wait states the store commits on the acceptance edge, so it must see the live inputs
  assign use_in     = (state == IDLE);
  assign eff_addr   = use_in ? addr[AW+1:0] : addr_q;
  assign eff_wdata  = use_in ? wdata : wdata_q;
  assign eff_funct3 = use_in ? funct3 : funct3_q;
  assign eff_write  = use_in ? mem_write : write_q;
  assign eff_err    = access_err(eff_funct3, eff_addr[1:0], eff_write);

  assign commit = !rst && eff_write && !eff_err &&
                  ((state == IDLE && req && WAIT_CYCLES == 0) ||
                   (state == BUSY && cnt == CNT_ONE));

  always_comb begin
    be     = 4'b0000;
    wlanes = eff_wdata;
    case (eff_funct3[1:0])
      2'b00: begin
        be[eff_addr[1:0]] = 1'b1;
        wlanes            = {4{eff_wdata[7:0]}};
      end
      2'b01: begin
        be     = eff_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{eff_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[eff_addr[AW+1:2]][i] <= wlanes[i];
      end
    end
  end

  assign rd_word = ram[addr_q[AW+1:2]];

  // Output next-values: the completion is registered out of DONE
  always_comb begin
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'd0;
    if (state == DONE) begin
      ready_d = 1'b1;
      err_d   = access_err(funct3_q, addr_q[1:0], write_q);
      if (!err_d && !write_q) rdata_d = load_extract(funct3_q, addr_q[1:0], rd_word);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready        <= 1'b0;
      misalign_err <= 1'b0;
      rdata        <= 32'd0;
    end else begin
      ready        <= ready_d;
      misalign_err <= err_d;
      rdata        <= rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: unit 0 is built with no wait states,
// unit 1 with the default two; both share one clock.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       mem_read;
  logic [1:0]       mem_write;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0][2:0]  funct3;

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1;
  logic        err0, err1;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .addr(addr[0]), .wdata(wdata[0]), .funct3(funct3[0]),
    .rdata(rdata0), .ready(ready0), .misalign_err(err0)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .addr(addr[1]), .wdata(wdata[1]), .funct3(funct3[1]),
    .rdata(rdata1), .ready(ready1), .misalign_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic get_ready(input int u);
    return (u == 0) ? ready0 : ready1;
  endfunction

  function automatic logic get_err(input int u);
    return (u == 0) ? err0 : err1;
  endfunction

  function automatic logic [31:0] get_rdata(input int u);
    return (u == 0) ? rdata0 : rdata1;
  endfunction

  // Deasserted request with garbage on the other inputs
  task automatic idle_inputs(input int u);
    mem_read[u]  = 1'b0;
    mem_write[u] = 1'b0;
    addr[u]      = $urandom;
    wdata[u]     = $urandom;
    funct3[u]    = 3'($urandom_range(0, 7));
  endtask

  // One request, held for exactly its acceptance edge; checks latency, result and pulse width
  task automatic do_req(input int u, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int lat;
    int exp_lat;
    logic [31:0] exp_v;
    exp_lat      = (u == 0) ? 1 : 3;
    mem_read[u]  = rd;
    mem_write[u] = wr;
    addr[u]      = a;
    wdata[u]     = wd;
    funct3[u]    = f3;
    exp_q.push_back(exp_rdata);
    @(posedge clk); #1;
    idle_inputs(u);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!get_ready(u) && lat < 20);
    exp_v = exp_q.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (get_ready(u)) begin
      check({tag, "_err"}, 32'(get_err(u)), 32'(exp_err));
      if (!wr || exp_err) check({tag, "_rdata"}, get_rdata(u), exp_v);
      @(posedge clk); #1;
      check({tag, "_ready_drop"}, 32'(get_ready(u)), 32'd0);
      check({tag, "_rdata_drop"}, get_rdata(u), 32'd0);
    end
  endtask

  // Store accepted, then reset on the next edge while BUSY
  task automatic reset_in_busy(input logic [31:0] a, input logic [31:0] wd);
    logic seen;
    mem_read[1]  = 1'b0;
    mem_write[1] = 1'b1;
    addr[1]      = a;
    wdata[1]     = wd;
    funct3[1]    = 3'b010;
    @(posedge clk); #1;
    idle_inputs(1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    check("rst_busy_ready", 32'(ready1), 32'd0);
    check("rst_busy_err", 32'(err1), 32'd0);
    check("rst_busy_rdata", rdata1, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready1) seen = 1'b1;
    end
    check("rst_busy_no_ready", 32'(seen), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b11;
    idle_inputs(0);
    idle_inputs(1);
    repeat (2) @(posedge clk);
    #1;
    rst = 2'b00;
    check("reset_ready1", 32'(ready1), 32'd0);
    check("reset_err1", 32'(err1), 32'd0);
    check("reset_rdata1", rdata1, 32'd0);
    check("reset_ready0", 32'(ready0), 32'd0);
    check("reset_rdata0", rdata0, 32'd0);

    // Word store / load
    do_req(1, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0, "sw_10");
    do_req(1, 1, 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0, "lw_10");

    // Byte store into lane 1, then byte loads
    do_req(1, 0, 1, 32'h11, 32'h000000A5, 3'b000, 32'h0, 0, "sb_11");
    do_req(1, 1, 0, 32'h10, 32'h0, 3'b010, 32'hDEADA5EF, 0, "lw_10_after_sb");
    do_req(1, 1, 0, 32'h11, 32'h0, 3'b000, 32'hFFFFFFA5, 0, "lb_11");
    do_req(1, 1, 0, 32'h11, 32'h0, 3'b100, 32'h000000A5, 0, "lbu_11");

    // Half store into the upper half, lower half preserved
    do_req(1, 0, 1, 32'h20, 32'h7777BEEF, 3'b010, 32'h0, 0, "sw_20");
    do_req(1, 0, 1, 32'h22, 32'h00008001, 3'b001, 32'h0, 0, "sh_22");
    do_req(1, 1, 0, 32'h22, 32'h0, 3'b001, 32'hFFFF8001, 0, "lh_22");
    do_req(1, 1, 0, 32'h22, 32'h0, 3'b101, 32'h00008001, 0, "lhu_22");
    do_req(1, 1, 0, 32'h20, 32'h0, 3'b010, 32'h8001BEEF, 0, "lw_20");
    do_req(1, 1, 0, 32'h23, 32'h0, 3'b000, 32'hFFFFFF80, 0, "lb_23");
    do_req(1, 1, 0, 32'h20, 32'h0, 3'b101, 32'h0000BEEF, 0, "lhu_20");

    // Error cases: no data, no RAM write
    do_req(1, 1, 0, 32'h13, 32'h0, 3'b010, 32'h0, 1, "lw_13_misalign");
    do_req(1, 0, 1, 32'h21, 32'h00001234, 3'b001, 32'h0, 1, "sh_21_misalign");
    do_req(1, 1, 0, 32'h20, 32'h0, 3'b011, 32'h0, 1, "ld_f3_011");
    do_req(1, 1, 0, 32'h20, 32'h0, 3'b110, 32'h0, 1, "ld_f3_110");
    do_req(1, 0, 1, 32'h20, 32'h00000000, 3'b100, 32'h0, 1, "st_f3_100");
    do_req(1, 1, 0, 32'h20, 32'h0, 3'b010, 32'h8001BEEF, 0, "lw_20_after_errs");

    // Reset while a store is pending drops it
    do_req(1, 0, 1, 32'h30, 32'h11111111, 3'b010, 32'h0, 0, "sw_30_old");
    reset_in_busy(32'h30, 32'h12345678);
    do_req(1, 1, 0, 32'h30, 32'h0, 3'b010, 32'h11111111, 0, "lw_30_after_rst");

    // No wait states, both strobes high acts as a store; address aliasing
    do_req(0, 1, 1, 32'h40, 32'hCAFEF00D, 3'b010, 32'h0, 0, "w0_rw_sw_40");
    do_req(0, 1, 0, 32'h40, 32'h0, 3'b010, 32'hCAFEF00D, 0, "w0_lw_40");
    do_req(0, 1, 0, 32'h40 + 32'(4 * DEPTH), 32'h0, 3'b010, 32'hCAFEF00D, 0, "w0_lw_alias");
    do_req(0, 1, 0, 32'h41, 32'h0, 3'b001, 32'h0, 1, "w0_lh_41_misalign");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
